// File: rtl/fft_pkg.sv
// Shared FFT datapath types and defaults used by the butterfly feeder and the butterfly itself.
package fft_pkg;

    localparam int FFT_WIDTH = 15;
    localparam int FFT_LANES = 4;

    typedef logic signed [FFT_WIDTH-1:0] sample_t;
    typedef sample_t [FFT_LANES-1:0]     lane_vec_t;

    // Beat counter spans a full frame: HALF fill beats plus HALF pair beats.
    function automatic int cnt_width(input int half);
        return $clog2(2 * half);
    endfunction

endpackage

// File: rtl/bf2_delay_ram.sv
// HALF-deep delay buffer holding the first half-frame; one write port, one registered read port.
module bf2_delay_ram
    import fft_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 2 * FFT_LANES * FFT_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto RAM/plain flops; only the read register is reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // The read register doubles as the operand-1 output register, so it drops to 0 on idle cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
        else            rd_data <= '0;
    end

endmodule

// File: rtl/bf2_pair_buffer.sv
// Feeds the radix-2 butterfly: buffers the first half-frame, then pairs each buffered beat with its second-half partner.
module bf2_pair_buffer
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int LANES = FFT_LANES,
    parameter int HALF  = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic [LANES-1:0][WIDTH-1:0]  din_R,
    input  logic [LANES-1:0][WIDTH-1:0]  din_Q,
    output logic [LANES-1:0][WIDTH-1:0]  dout_R_1,
    output logic [LANES-1:0][WIDTH-1:0]  dout_R_2,
    output logic [LANES-1:0][WIDTH-1:0]  dout_Q_1,
    output logic [LANES-1:0][WIDTH-1:0]  dout_Q_2,
    output logic                         bf_en,
    output logic                         bf_sof,
    output logic                         sof_err
);

    localparam int CW = cnt_width(HALF);
    localparam int AW = CW - 1;
    localparam int LW = LANES * WIDTH;
    localparam logic [CW-1:0] PAIR_FIRST = CW'(HALF);

    logic [CW-1:0] cnt;
    logic [CW-1:0] eff_cnt;
    logic          active;
    logic          restart;
    logic          accept;
    logic          wr_en;
    logic          rd_en;
    logic [2*LW-1:0] rd_data;

    // NOTE: combinational logic assigns every output on every path, so no latch can be inferred.
    always_comb begin
        restart = in_valid & in_sof;
        eff_cnt = restart ? '0 : cnt;
        accept  = in_valid & (active | in_sof);
        wr_en   = accept & ~eff_cnt[CW-1];
        rd_en   = accept &  eff_cnt[CW-1];
    end

    bf2_delay_ram #(
        .DEPTH (HALF),
        .DW    (2 * LW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_addr (eff_cnt[AW-1:0]),
        .wr_data ({din_R, din_Q}),
        .rd_en   (rd_en),
        .rd_addr (eff_cnt[AW-1:0]),
        .rd_data (rd_data)
    );

    assign dout_R_1 = rd_data[2*LW-1:LW];
    assign dout_Q_1 = rd_data[LW-1:0];

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            active   <= 1'b0;
            sof_err  <= 1'b0;
            bf_en    <= 1'b0;
            bf_sof   <= 1'b0;
            dout_R_2 <= '0;
            dout_Q_2 <= '0;
        end else begin
            // An sof mid-frame discards the partial frame; the counter wraps naturally at 2*HALF.
            sof_err  <= restart & active & (cnt != '0);
            active   <= active | restart;
            if (accept) cnt <= eff_cnt + CW'(1);
            bf_en    <= rd_en;
            bf_sof   <= rd_en & (eff_cnt == PAIR_FIRST);
            dout_R_2 <= rd_en ? din_R : '0;
            dout_Q_2 <= rd_en ? din_Q : '0;
        end
    end

endmodule

// File: doc/bf2_pair_buffer.md
Name: bf2_pair_buffer

Overview:
- Upstream feeder for the 4-lane radix-2 butterfly (BF2I) in the pipelined FFT datapath.
- Accepts a streaming frame of complex samples, LANES per beat, and holds the first half-frame in a delay buffer.
- During the second half-frame it presents each buffered beat (operand 1) aligned with the matching incoming beat (operand 2), plus the butterfly enable.
- Its outputs connect directly to the butterfly's din_R_1/din_R_2/din_Q_1/din_Q_2 and en.

Parameters:
- WIDTH, 15, signed sample width per I/Q component. Equals the butterfly input width.
- LANES, 4, parallel samples per beat. Equals the butterfly DEPTH.
- HALF, 16, beats per half-frame, i.e. the butterfly span in beats. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid. No backpressure.
- in_sof  in  1  first beat of a frame. Qualified by in_valid.
- din_R  in  LANES x WIDTH signed  in-phase samples
- din_Q  in  LANES x WIDTH signed  quadrature samples
- dout_R_1  out  LANES x WIDTH signed  buffered (first-half) I operand
- dout_R_2  out  LANES x WIDTH signed  current (second-half) I operand
- dout_Q_1  out  LANES x WIDTH signed  buffered Q operand
- dout_Q_2  out  LANES x WIDTH signed  current Q operand
- bf_en  out  1  butterfly enable; operands valid
- bf_sof  out  1  first pair of a frame. Asserted only with bf_en.
- sof_err  out  1  one-cycle pulse on an in_sof that aborts a partial frame

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. Every output register clears to 0: operands, bf_en, bf_sof, sof_err. The beat counter clears to 0 and the frame-active flag clears. Buffer RAM contents are don't-care and are not reset.
- State: beat counter cnt, width log2(2*HALF), plus an active flag. cnt MSB is the phase: 0 = FILL, 1 = PAIR.
- Idle: active=0. Beats without in_sof are dropped. The counter holds and no buffer write occurs.
- Start: in_valid & in_sof sets active=1 and treats the beat as cnt=0 (FILL, address 0).
- FILL, cnt < HALF: on in_valid, write {din_R,din_Q} to buf[cnt[log2 HALF-1:0]], then cnt++. No output.
- PAIR, cnt >= HALF: on in_valid, read buf[cnt low bits]. Next cycle, drive dout_*_1 = buffered beat and dout_*_2 = registered current beat, with bf_en=1. Latency: registered output exactly 1 cycle after the second-half input beat.
- bf_sof=1 on the pair produced from cnt == HALF.
- Wrap: at cnt == 2*HALF-1 with in_valid, cnt returns to 0 and active stays 1. The next beat is FILL of the next frame whether or not in_sof is set.
- Gaps: in_valid=0 holds cnt. The next cycle has bf_en=0 and bf_sof=0, and operand registers drive 0. Gaps are legal in both phases.
- Early sof: in_valid & in_sof while active and cnt != 0 pulses sof_err for 1 cycle. The partial frame is discarded, this beat restarts at cnt=0, and no pair is emitted for it.
- An in_sof at cnt == 0 is normal and produces no error.
- Widths: pure data movement, no arithmetic, no width growth. Values pass bit-exact. Output width WIDTH matches the butterfly, whose own outputs grow to WIDTH+1.
- Reset mid-frame: everything clears immediately and asynchronously. The block waits for a new in_sof.
- Buffer: single-port-equivalent. FILL writes and PAIR reads never occur in the same cycle for the same frame. Synthesizable as a register array or 1R1W RAM with a registered read.

Decomposition:
- Package fft_pkg holds:
  - the sample typedef: signed [WIDTH-1:0]
  - the lane-vector typedef
  - the helper function for counter width, clog2(2*HALF)
  - the shared default constants WIDTH=15 and LANES=4, also used by the butterfly
- One natural sub-module: bf2_delay_ram, an HALF-deep x (2*LANES*WIDTH) buffer with a write port and a registered read port.
- Counter, phase and sof logic stay in the top.

Test Plan:
- Normal frame (HALF=4, LANES=4): 8 contiguous beats with sof on beat 0, lane k of beat b carrying R=16*b+k and Q=-(16*b+k).
  - No bf_en during beats 0-3.
  - Beats 4-7 produce bf_en one cycle later, with dout_R_1[k]=16*(b-4)+k and dout_R_2[k]=16*b+k.
  - bf_sof only on the first pair.
- Back-to-back frames: 16 beats with sof only on beat 0. Pairs appear for beats 4-7 and 12-15, the second frame's bf_sof is asserted, and sof_err=0.
- Gaps: insert in_valid=0 cycles after beats 2 and 5. Pairing is unchanged, bf_en=0 with operands 0 in gap cycles, and there is no beat loss.
- Early sof: sof again at beat 2 of a frame. sof_err pulses once, the new frame pairs against the restarted data, and no stale pair is emitted.
- Extremes: inputs of -16384 and +16383 pass bit-exact on all lanes.
- Reset mid-frame: rstn low during PAIR beat 5. All outputs are 0 immediately. After release, beats without sof are ignored until a new sof.
